packet_dispatcher_egress_demux: RTL and testbench

Egress stage placed directly after the packet dispatcher. It takes the dispatcher's single output stream, whose first beat carries the FIFO-select and IPv4 total-length metadata, and steers each packet whole to one of `2**AXIS_FIFO_SELECT_WIDTH` per-queue AXI-Stream outputs. It checks each packet's byte count against the metadata length and keeps saturating per-queue packet, byte and length-error counters for host readout.

---
 rtl/packet_dispatcher_pkg.sv | 25 ++
 rtl/packet_dispatcher_egress_demux_sat_counter_add.sv | 30 +++
 rtl/packet_dispatcher_egress_demux.sv | 186 ++++++++++++++++++
 tb/tb_packet_dispatcher_egress_demux.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_dispatcher_pkg.sv
// Shared definitions for the packet dispatcher egress path.
// Holds the state encoding, framing constants and byte counting helper.
package packet_dispatcher_pkg;

    typedef enum logic {
        STATE_SOP  = 1'b0,
        STATE_BODY = 1'b1
    } state_t;

    localparam int L2_HEADER_BYTES = 14;
    localparam int POPCOUNT_MAX_WIDTH = 256;

    // Number of set bits; callers zero-extend their keep vector.
    function automatic int unsigned popcount(
        input logic [POPCOUNT_MAX_WIDTH-1:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_WIDTH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/packet_dispatcher_egress_demux_sat_counter_add.sv
// Saturating accumulator used for the per-queue statistics.
// Clear has priority over an add; sums stick at all-ones.
module sat_counter_add #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [ADD_WIDTH-1:0] add,
    output logic [WIDTH-1:0]     count
);

    logic [WIDTH:0] sum;

    // Widen by one bit so overflow is visible as a carry.
    always_comb begin
        sum = {1'b0, count} + (WIDTH + 1)'(add);
    end

    // Clear first, otherwise add with saturation.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/packet_dispatcher_egress_demux.sv
// Egress demux: steers whole packets to per-queue AXI-Stream outputs
// and keeps saturating per-queue packet, byte and length-error counts.
module packet_dispatcher_egress_demux #(
    parameter int AXIS_DATA_WIDTH        = 64,
    parameter int AXIS_KEEP_WIDTH        = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_FIFO_SELECT_WIDTH = 2,
    parameter int AXIS_PKT_LEN_WIDTH     = 16,
    parameter int AXIS_METADATA_WIDTH    =
        AXIS_FIFO_SELECT_WIDTH + AXIS_PKT_LEN_WIDTH,
    parameter int L2_HEADER_BYTES        =
        packet_dispatcher_pkg::L2_HEADER_BYTES,
    parameter int STAT_COUNTER_WIDTH     = 32,
    localparam int NQ = 2 ** AXIS_FIFO_SELECT_WIDTH,
    localparam int CW = STAT_COUNTER_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_egress_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]     s_axis_egress_tkeep,
    input  logic [AXIS_METADATA_WIDTH-1:0] s_axis_egress_tmetadata,
    input  logic                           s_axis_egress_tvalid,
    input  logic                           s_axis_egress_tlast,
    output logic                           s_axis_egress_tready,
    output logic [AXIS_DATA_WIDTH-1:0]     m_axis_egress_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]     m_axis_egress_tkeep,
    output logic                           m_axis_egress_tlast,
    output logic [NQ-1:0]                  m_axis_egress_tvalid,
    input  logic [NQ-1:0]                  m_axis_egress_tready,
    input  logic                           rst_stat_counters,
    output logic [NQ*CW-1:0]               stat_pkt_count,
    output logic [NQ*CW-1:0]               stat_byte_count,
    output logic [NQ*CW-1:0]               stat_len_err_count
);

    import packet_dispatcher_pkg::*;

    localparam int SW    = AXIS_FIFO_SELECT_WIDTH;
    localparam int LW    = AXIS_PKT_LEN_WIDTH;
    localparam int ACC_W = LW + 1;

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     sel_q;
    logic [SW-1:0]     cur_sel;
    logic [SW-1:0]     meta_sel;
    logic [LW-1:0]     meta_len;
    logic [ACC_W-1:0]  exp_len_q;
    logic [ACC_W-1:0]  exp_cur;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  beat_bytes;
    logic [ACC_W:0]    acc_sum;
    logic              in_fire;
    logic              pkt_end;
    logic              len_err;
    logic              stat_clr;

    logic                       out_valid;
    logic [SW-1:0]              out_sel;

    assign meta_sel = s_axis_egress_tmetadata[AXIS_METADATA_WIDTH-1 -: SW];
    assign meta_len = s_axis_egress_tmetadata[LW-1:0];

    assign s_axis_egress_tready =
        !out_valid || m_axis_egress_tready[out_sel];
    assign in_fire  = s_axis_egress_tvalid && s_axis_egress_tready;
    assign pkt_end  = in_fire && s_axis_egress_tlast;
    assign stat_clr = rst || rst_stat_counters;

    assign beat_bytes = ACC_W'(popcount(
        POPCOUNT_MAX_WIDTH'(s_axis_egress_tkeep)));
    assign acc_sum = {1'b0, acc_q} + {1'b0, beat_bytes};
    assign len_err = acc_next != exp_cur;

    // First beat takes routing and length from metadata; later beats reuse it.
    always_comb begin
        cur_sel  = sel_q;
        exp_cur  = exp_len_q;
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        if (state == STATE_SOP) begin
            cur_sel  = meta_sel;
            exp_cur  = {1'b0, meta_len} + ACC_W'(L2_HEADER_BYTES);
            acc_next = beat_bytes;
        end
    end

    // Next state: leave SOP on a non-last first beat, return on tlast.
    always_comb begin
        state_next = state;
        if (in_fire) begin
            unique case (state)
                STATE_SOP:  if (!s_axis_egress_tlast) state_next = STATE_BODY;
                STATE_BODY: if (s_axis_egress_tlast) state_next = STATE_SOP;
                default:    state_next = STATE_SOP;
            endcase
        end
    end

    // Packet framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_SOP;
        end else begin
            state <= state_next;
        end
    end

    // Per-packet context: queue, expected length, running byte count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            exp_len_q <= '0;
            acc_q     <= '0;
        end else if (in_fire) begin
            sel_q     <= cur_sel;
            exp_len_q <= exp_cur;
            acc_q     <= acc_next;
        end
    end

    // Single output register stage shared by all queues.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid           <= 1'b0;
            out_sel             <= '0;
            m_axis_egress_tdata <= '0;
            m_axis_egress_tkeep <= '0;
            m_axis_egress_tlast <= 1'b0;
        end else if (s_axis_egress_tready) begin
            out_valid <= s_axis_egress_tvalid;
            if (s_axis_egress_tvalid) begin
                out_sel             <= cur_sel;
                m_axis_egress_tdata <= s_axis_egress_tdata;
                m_axis_egress_tkeep <= s_axis_egress_tkeep;
                m_axis_egress_tlast <= s_axis_egress_tlast;
            end
        end
    end

    // Expand the held beat's queue into a one-hot valid.
    always_comb begin
        m_axis_egress_tvalid = '0;
        if (out_valid) begin
            m_axis_egress_tvalid[out_sel] = 1'b1;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        logic hit;
        assign hit = pkt_end && (cur_sel == SW'(q));

        sat_counter_add #(
            .WIDTH     (CW),
            .ADD_WIDTH (1)
        ) u_pkt (
            .clk   (clk),
            .clr   (stat_clr),
            .en    (hit),
            .add   (1'b1),
            .count (stat_pkt_count[q*CW +: CW])
        );

        sat_counter_add #(
            .WIDTH     (CW),
            .ADD_WIDTH (ACC_W)
        ) u_byte (
            .clk   (clk),
            .clr   (stat_clr),
            .en    (hit),
            .add   (acc_next),
            .count (stat_byte_count[q*CW +: CW])
        );

        sat_counter_add #(
            .WIDTH     (CW),
            .ADD_WIDTH (1)
        ) u_err (
            .clk   (clk),
            .clr   (stat_clr),
            .en    (hit && len_err),
            .add   (1'b1),
            .count (stat_len_err_count[q*CW +: CW])
        );
    end

endmodule

// File: tb/tb_packet_dispatcher_egress_demux.sv
// Bench for the egress demux: table vectors, directed corner cases
// and randomized packets against a packet-level reference model.
module tb_packet_dispatcher_egress_demux;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int NQ = 4;
    localparam int CW = 32;
    localparam longint SATMAX = 64'd4294967295;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_tdata;
    logic [KW-1:0]   s_tkeep;
    logic [17:0]     s_tmeta;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [NQ-1:0]   m_tvalid;
    logic [NQ-1:0]   m_tready;
    logic            rst_stat_counters;
    logic [NQ*CW-1:0] stat_pkt;
    logic [NQ*CW-1:0] stat_byte;
    logic [NQ*CW-1:0] stat_err;

    always #5 clk = ~clk;

    packet_dispatcher_egress_demux dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis_egress_tdata     (s_tdata),
        .s_axis_egress_tkeep     (s_tkeep),
        .s_axis_egress_tmetadata (s_tmeta),
        .s_axis_egress_tvalid    (s_tvalid),
        .s_axis_egress_tlast     (s_tlast),
        .s_axis_egress_tready    (s_tready),
        .m_axis_egress_tdata     (m_tdata),
        .m_axis_egress_tkeep     (m_tkeep),
        .m_axis_egress_tlast     (m_tlast),
        .m_axis_egress_tvalid    (m_tvalid),
        .m_axis_egress_tready    (m_tready),
        .rst_stat_counters       (rst_stat_counters),
        .stat_pkt_count          (stat_pkt),
        .stat_byte_count         (stat_byte),
        .stat_len_err_count      (stat_err)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            q;
    } beat_t;

    typedef struct {
        int         sel;
        int         len;
        int         beats;
        logic [7:0] lkeep;
        int         exp_bytes;
        int         exp_err;
    } vec_t;

    beat_t  expq[$];
    longint exp_pkt[NQ];
    longint exp_byte[NQ];
    longint exp_err[NQ];
    int     rmode = 0;
    int     bp_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > SATMAX) ? SATMAX : v;
    endfunction

    task automatic model_clear();
        for (int q = 0; q < NQ; q++) begin
            exp_pkt[q] = 0;
            exp_byte[q] = 0;
            exp_err[q] = 0;
        end
    endtask

    task automatic check_counters(input string tag);
        for (int q = 0; q < NQ; q++) begin
            chk($sformatf("%s_pkt[%0d]", tag, q),
                stat_pkt[q*CW +: CW], exp_pkt[q]);
            chk($sformatf("%s_byte[%0d]", tag, q),
                stat_byte[q*CW +: CW], exp_byte[q]);
            chk($sformatf("%s_err[%0d]", tag, q),
                stat_err[q*CW +: CW], exp_err[q]);
        end
    endtask

    // Drain the expected stream with a bounded wait.
    task automatic wait_idle();
        int n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", 128'(expq.size()), 128'd0);
    endtask

    // Send one packet starting at a negedge; ends at a negedge.
    task automatic send_pkt(input int sel, input int len, input int nbeats,
                            input logic [7:0] lkeep, input int alt_sel,
                            input bit clr_last, input bit noend,
                            output int stalls);
        int bytes = 0;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic l;
        int ms;
        bit acc;
        int w;
        stalls = 0;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom};
            k = (b == nbeats - 1) ? lkeep : 8'hFF;
            l = (b == nbeats - 1) && !noend;
            ms = (alt_sel >= 0 && b >= 3) ? alt_sel : sel;
            s_tdata = d;
            s_tkeep = k;
            s_tlast = l;
            s_tmeta = {2'(ms), 16'(len)};
            s_tvalid = 1'b1;
            rst_stat_counters = clr_last && l;
            acc = 1'b0;
            w = 0;
            while (!acc) begin
                #1;
                acc = s_tready;
                @(posedge clk);
                if (!acc) begin
                    w++;
                    stalls++;
                    if (w > 200) begin
                        errors++;
                        $display("FAIL accept_timeout: beat %0d not taken", b);
                        s_tvalid = 1'b0;
                        rst_stat_counters = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
            expq.push_back('{d, k, l, sel});
            bytes += $countones(k);
            @(negedge clk);
            rst_stat_counters = 1'b0;
            chk("beat_latency", {m_tvalid, m_tdata, m_tkeep, m_tlast},
                {4'(1 << sel), d, k, l});
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (!noend) begin
            if (clr_last) begin
                model_clear();
            end else begin
                exp_pkt[sel] = sat(exp_pkt[sel] + 1);
                exp_byte[sel] = sat(exp_byte[sel] + bytes);
                if (bytes != len + 14) exp_err[sel] = sat(exp_err[sel] + 1);
            end
        end
    endtask

    // Downstream ready policy: all ready, random, or scripted stall.
    initial begin
        m_tready = '1;
        forever begin
            @(negedge clk);
            if (rmode == 1) begin
                m_tready = 4'($urandom);
            end else if (rmode == 2) begin
                bp_cnt++;
                m_tready = 4'b1111;
                if (bp_cnt >= 4 && bp_cnt <= 8) m_tready[1] = 1'b0;
                m_tready[0] = bp_cnt[0];
                #2;
                if (bp_cnt >= 4 && bp_cnt <= 8) begin
                    chk("bp_hold", {m_tvalid, s_tready}, {4'b0010, 1'b0});
                end
            end else begin
                bp_cnt = 0;
                m_tready = '1;
            end
        end
    end

    // Output monitor: one-hot, hold-while-stalled, in-order stream.
    initial begin
        logic [76:0] prev;
        logic [76:0] cur;
        bit have_prev = 0;
        bit hs;
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                have_prev = 0;
            end else begin
                cur = {m_tvalid, m_tdata, m_tkeep, m_tlast};
                checks++;
                if (!$onehot0(m_tvalid)) begin
                    errors++;
                    $display("FAIL onehot: got %b expected one-hot or zero",
                             m_tvalid);
                end
                if (have_prev) chk("hold_stable", cur, prev);
                hs = |(m_tvalid & m_tready);
                if (hs) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream: got beat %0h expected none",
                                 cur);
                    end else begin
                        e = expq.pop_front();
                        chk("stream", cur,
                            {4'(1 << e.q), e.data, e.keep, e.last});
                    end
                end
                have_prev = (m_tvalid != 0) && !hs;
                prev = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   tbl_pkt[NQ];
        int   tbl_byte[NQ];
        int   tbl_err[NQ];
        int   st;
        int   tot;
        int   sel;
        int   nb;
        int   len;
        int   bytes;
        logic [7:0] lk;

        tbl[0] = '{2, 58, 9, 8'h03, 66, 1};
        tbl[1] = '{0, 50, 8, 8'hFF, 64, 0};
        tbl[2] = '{1, 40, 7, 8'h3F, 54, 0};
        tbl[3] = '{3, 0, 1, 8'hFF, 8, 1};
        tbl[4] = '{0, 46, 8, 8'h0F, 60, 0};
        tbl[5] = '{1, 1, 2, 8'h01, 9, 1};
        for (int q = 0; q < NQ; q++) begin
            tbl_pkt[q] = 0;
            tbl_byte[q] = 0;
            tbl_err[q] = 0;
        end
        model_clear();

        rst = 1'b1;
        s_tdata = '0;
        s_tkeep = '0;
        s_tmeta = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        rst_stat_counters = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_out", {m_tdata, m_tkeep, m_tlast}, 128'd0);
        chk("rst_ready", 128'(s_tready), 128'd1);
        check_counters("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_pkt(tbl[i].sel, tbl[i].len, tbl[i].beats, tbl[i].lkeep,
                     -1, 0, 0, st);
            wait_idle();
            sel = tbl[i].sel;
            tbl_pkt[sel] += 1;
            tbl_byte[sel] += tbl[i].exp_bytes;
            tbl_err[sel] += tbl[i].exp_err;
            chk($sformatf("tbl%0d_pkt", i), stat_pkt[sel*CW +: CW],
                tbl_pkt[sel]);
            chk($sformatf("tbl%0d_byte", i), stat_byte[sel*CW +: CW],
                tbl_byte[sel]);
            chk($sformatf("tbl%0d_err", i), stat_err[sel*CW +: CW],
                tbl_err[sel]);
        end

        rst_stat_counters = 1'b1;
        @(negedge clk);
        rst_stat_counters = 1'b0;
        model_clear();
        tot = 0;
        send_pkt(0, 10, 3, 8'hFF, -1, 0, 0, st);
        tot += st;
        send_pkt(1, 18, 4, 8'hFF, -1, 0, 0, st);
        tot += st;
        send_pkt(3, 8, 3, 8'h3F, -1, 0, 0, st);
        tot += st;
        send_pkt(0, 26, 5, 8'hFF, -1, 0, 0, st);
        tot += st;
        wait_idle();
        chk("b2b_stalls", 128'(tot), 128'd0);
        chk("b2b_pkt0", stat_pkt[0*CW +: CW], 128'd2);
        chk("b2b_pkt1", stat_pkt[1*CW +: CW], 128'd1);
        chk("b2b_pkt2", stat_pkt[2*CW +: CW], 128'd0);
        chk("b2b_pkt3", stat_pkt[3*CW +: CW], 128'd1);
        chk("b2b_byte0", stat_byte[0*CW +: CW], 128'd64);
        chk("b2b_byte1", stat_byte[1*CW +: CW], 128'd32);
        chk("b2b_byte3", stat_byte[3*CW +: CW], 128'd22);
        chk("b2b_err", {stat_err[0*CW +: CW], stat_err[1*CW +: CW],
                        stat_err[3*CW +: CW]}, 128'd0);

        @(posedge clk);
        rmode = 2;
        @(negedge clk);
        send_pkt(1, 82, 12, 8'hFF, -1, 0, 0, st);
        @(posedge clk);
        rmode = 0;
        @(negedge clk);
        wait_idle();
        chk("bp_stalls", 128'(st), 128'd5);
        check_counters("bp");

        send_pkt(1, 34, 6, 8'hFF, 3, 0, 0, st);
        wait_idle();
        check_counters("meta");

        send_pkt(0, 10, 3, 8'hFF, -1, 1, 0, st);
        wait_idle();
        check_counters("clr");

        @(posedge clk);
        rmode = 1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            nb = $urandom_range(1, 6);
            lk = 8'hFF >> $urandom_range(0, 7);
            bytes = (nb - 1) * 8 + $countones(lk);
            if ($urandom_range(0, 1) == 1 && bytes >= 14) len = bytes - 14;
            else len = $urandom_range(0, 60);
            send_pkt(sel, len, nb, lk, int'($urandom_range(0, 3)), 0, 0, st);
        end
        @(posedge clk);
        rmode = 0;
        @(negedge clk);
        wait_idle();
        check_counters("rand");

        send_pkt(2, 30, 3, 8'hFF, -1, 0, 1, st);
        rst = 1'b1;
        @(posedge clk);
        expq.delete();
        @(negedge clk);
        chk("mid_rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("mid_rst_out", {m_tdata, m_tkeep, m_tlast}, 128'd0);
        chk("mid_rst_ready", 128'(s_tready), 128'd1);
        model_clear();
        check_counters("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        send_pkt(2, 18, 4, 8'hFF, -1, 0, 0, st);
        wait_idle();
        check_counters("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
